// File: rtl/wb_regfile.sv
// ---------------------------------------------------------------------------
// wb_regfile
//   Write-back-side register file and in-flight scoreboard for the RV32I
//   pipeline. Selects the write-back data from the MEM/WB stage outputs,
//   commits it to the 32x32 architectural register file, provides
//   write-first bypassed reads to ID, and tracks outstanding writes per
//   register with 2-bit counters to raise stall on RAW hazards and on
//   WAW counter saturation.
//
// Ports
//   clk, rst_n      : rising-edge clock, asynchronous active-low reset
//   wb_mem_output   : load data from WB
//   wb_alu_output   : ALU result from WB
//   wb_imm          : immediate (LUI) from WB
//   wb_pc_plus_4    : link address from WB
//   wb_rd           : WB destination register
//   wb_memtoreg     : write-data select (00 alu, 01 mem, 10 pc+4, 11 imm)
//   wb_regwrite     : commit wb_data to wb_rd this cycle
//   wb_release      : WB instruction held a reservation on wb_rd
//   id_valid        : instruction present in ID
//   id_rs1, id_rs2  : ID source registers
//   id_rd           : ID destination register
//   id_regwrite     : ID instruction will write id_rd
//   rs1_data        : bypassed read of id_rs1
//   rs2_data        : bypassed read of id_rs2
//   wb_data         : selected write-back data (combinational)
//   stall           : ID must hold this cycle
// ---------------------------------------------------------------------------
module wb_regfile (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] wb_mem_output,
    input  logic [31:0] wb_alu_output,
    input  logic [31:0] wb_imm,
    input  logic [31:0] wb_pc_plus_4,
    input  logic [4:0]  wb_rd,
    input  logic [1:0]  wb_memtoreg,
    input  logic        wb_regwrite,
    input  logic        wb_release,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  id_rd,
    input  logic        id_regwrite,
    output logic [31:0] rs1_data,
    output logic [31:0] rs2_data,
    output logic [31:0] wb_data,
    output logic        stall
);

    // x0 has no storage; all arrays start at index 1.
    logic [31:0] regs [1:31];
    logic [1:0]  cnt  [1:31];

    logic [31:1] rel;      // WB frees a reservation on r this cycle
    logic [31:1] inc;      // ID issues a new reservation on r this cycle
    logic [31:1] eff_nz;   // effective outstanding count (cnt - rel) is nonzero
    logic        issue;
    logic        raw_rs1;
    logic        raw_rs2;
    logic        waw_sat;

    // ------------------------------------------------------------------
    // Write-back data select
    // ------------------------------------------------------------------
    always_comb begin
        wb_data = wb_alu_output;
        unique case (wb_memtoreg)
            2'b00: wb_data = wb_alu_output;
            2'b01: wb_data = wb_mem_output;
            2'b10: wb_data = wb_pc_plus_4;
            2'b11: wb_data = wb_imm;
            default: wb_data = wb_alu_output;
        endcase
    end

    // ------------------------------------------------------------------
    // Bypassed reads (write-first)
    // ------------------------------------------------------------------
    always_comb begin
        rs1_data = '0;
        if (id_rs1 != 5'd0) begin
            if (wb_regwrite && (wb_rd == id_rs1)) begin
                rs1_data = wb_data;
            end else begin
                rs1_data = regs[id_rs1];
            end
        end
    end

    always_comb begin
        rs2_data = '0;
        if (id_rs2 != 5'd0) begin
            if (wb_regwrite && (wb_rd == id_rs2)) begin
                rs2_data = wb_data;
            end else begin
                rs2_data = regs[id_rs2];
            end
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard: release, effective count, stall, issue
    // ------------------------------------------------------------------
    always_comb begin
        rel    = '0;
        eff_nz = '0;
        for (int unsigned r = 1; r < 32; r++) begin
            rel[r] = wb_release && (wb_rd == 5'(r));
            // A release at count 0 is a protocol error; treat the effective
            // count as 0 rather than letting it wrap to 3.
            eff_nz[r] = (cnt[r] != 2'd0) && !((cnt[r] == 2'd1) && rel[r]);
        end
    end

    always_comb begin
        raw_rs1 = (id_rs1 != 5'd0) && eff_nz[id_rs1];
        raw_rs2 = (id_rs2 != 5'd0) && eff_nz[id_rs2];
        // Saturation looks at the raw count: a same-cycle release does not
        // make room for a fourth reservation until the next cycle.
        waw_sat = id_regwrite && (id_rd != 5'd0) && (cnt[id_rd] == 2'd3);
        stall   = id_valid && (raw_rs1 || raw_rs2 || waw_sat);
        issue   = id_valid && !stall;
    end

    always_comb begin
        inc = '0;
        for (int unsigned r = 1; r < 32; r++) begin
            inc[r] = issue && id_regwrite && (id_rd == 5'(r));
        end
    end

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 1; r < 32; r++) begin
                regs[r] <= '0;
            end
        end else if (wb_regwrite && (wb_rd != 5'd0)) begin
            regs[wb_rd] <= wb_data;
        end
    end

    // ------------------------------------------------------------------
    // In-flight counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 1; r < 32; r++) begin
                cnt[r] <= '0;
            end
        end else begin
            for (int unsigned r = 1; r < 32; r++) begin
                if (inc[r] && !rel[r]) begin
                    // Stall on saturation guarantees cnt < 3 here.
                    cnt[r] <= cnt[r] + 2'd1;
                end else if (rel[r] && !inc[r] && (cnt[r] != 2'd0)) begin
                    cnt[r] <= cnt[r] - 2'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Protocol checks
    // ------------------------------------------------------------------
    a_write_needs_release : assert property (
        @(posedge clk) disable iff (!rst_n)
        wb_regwrite |-> wb_release
    );

    a_release_not_empty : assert property (
        @(posedge clk) disable iff (!rst_n)
        (wb_release && (wb_rd != 5'd0)) |-> (cnt[wb_rd] != 2'd0)
    );

endmodule

// File: tb/tb_wb_regfile.sv
// ---------------------------------------------------------------------------
// tb_wb_regfile
//   Directed self-checking bench for wb_regfile. Inputs change just after
//   the falling edge; outputs are compared 1 ns later, away from the rising
//   edge that commits state.
// ---------------------------------------------------------------------------
module tb_wb_regfile;

    logic        clk;
    logic        rst_n;
    logic [31:0] wb_mem_output;
    logic [31:0] wb_alu_output;
    logic [31:0] wb_imm;
    logic [31:0] wb_pc_plus_4;
    logic [4:0]  wb_rd;
    logic [1:0]  wb_memtoreg;
    logic        wb_regwrite;
    logic        wb_release;
    logic        id_valid;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [4:0]  id_rd;
    logic        id_regwrite;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] wb_data;
    logic        stall;

    int checks = 0;
    int errors = 0;

    wb_regfile dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wb_mem_output (wb_mem_output),
        .wb_alu_output (wb_alu_output),
        .wb_imm        (wb_imm),
        .wb_pc_plus_4  (wb_pc_plus_4),
        .wb_rd         (wb_rd),
        .wb_memtoreg   (wb_memtoreg),
        .wb_regwrite   (wb_regwrite),
        .wb_release    (wb_release),
        .id_valid      (id_valid),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_rd         (id_rd),
        .id_regwrite   (id_regwrite),
        .rs1_data      (rs1_data),
        .rs2_data      (rs2_data),
        .wb_data       (wb_data),
        .stall         (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Return all stimulus (except reset) to quiet values.
    task automatic idle();
        wb_mem_output = '0;
        wb_alu_output = '0;
        wb_imm        = '0;
        wb_pc_plus_4  = '0;
        wb_rd         = '0;
        wb_memtoreg   = 2'b00;
        wb_regwrite   = 1'b0;
        wb_release    = 1'b0;
        id_valid      = 1'b0;
        id_rs1        = '0;
        id_rs2        = '0;
        id_rd         = '0;
        id_regwrite   = 1'b0;
    endtask

    // Advance through one rising edge to the next falling edge.
    task automatic next_cycle();
        @(negedge clk);
        idle();
    endtask

    // Present an ID instruction that reserves rd (no sources), let it commit.
    task automatic issue_rd(input logic [4:0] rd, input string name);
        id_valid    = 1'b1;
        id_rd       = rd;
        id_regwrite = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL %s: stall=%b expected 0", name, stall);
        end
        next_cycle();
    endtask

    // WB commits data to rd with a release.
    task automatic wb_write(input logic [4:0] rd, input logic [31:0] val);
        wb_rd         = rd;
        wb_memtoreg   = 2'b00;
        wb_alu_output = val;
        wb_regwrite   = 1'b1;
        wb_release    = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        id_rs1 = 5'd5;
        id_rs2 = 5'd0;
        wb_alu_output = 32'h0000_0077;
        #1;
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: stall=%b expected 0", stall); end
        checks++;
        if (rs1_data !== 32'h0) begin errors++; $display("FAIL reset_rd_x5: rs1_data=%h expected 0", rs1_data); end
        checks++;
        if (rs2_data !== 32'h0) begin errors++; $display("FAIL reset_rd_x0: rs2_data=%h expected 0", rs2_data); end
        checks++;
        if (wb_data !== 32'h0000_0077) begin errors++; $display("FAIL reset_wb_data: wb_data=%h expected 00000077", wb_data); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
        // No register may report an outstanding reservation after reset.
        for (int r = 1; r < 32; r++) begin
            id_valid = 1'b1;
            id_rs1   = 5'(r);
            #1;
            checks++;
            if (stall !== 1'b0) begin errors++; $display("FAIL reset_cnt_x%0d: stall=%b expected 0", r, stall); end
            #1;
        end
        next_cycle();
    endtask

    task automatic test_bypass();
        issue_rd(5'd3, "bypass_issue_x3");
        wb_write(5'd3, 32'h1234_5678);
        id_rs1 = 5'd3;
        #1;
        checks++;
        if (wb_data !== 32'h1234_5678) begin errors++; $display("FAIL bypass_wb_data: wb_data=%h expected 12345678", wb_data); end
        checks++;
        if (rs1_data !== 32'h1234_5678) begin errors++; $display("FAIL bypass_same_cycle: rs1_data=%h expected 12345678", rs1_data); end
        next_cycle();
        id_valid = 1'b1;
        id_rs1   = 5'd3;
        #1;
        checks++;
        if (rs1_data !== 32'h1234_5678) begin errors++; $display("FAIL bypass_next_cycle: rs1_data=%h expected 12345678", rs1_data); end
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL bypass_released: stall=%b expected 0", stall); end
        next_cycle();
    endtask

    task automatic test_memtoreg();
        logic [1:0]  sel [4];
        logic [31:0] exp [4];
        sel[0] = 2'b01; exp[0] = 32'hDEAD_BEEF;
        sel[1] = 2'b10; exp[1] = 32'h0000_0104;
        sel[2] = 2'b11; exp[2] = 32'hABCD_E000;
        sel[3] = 2'b00; exp[3] = 32'hA0A0_A0A0;
        for (int i = 0; i < 4; i++) begin
            issue_rd(5'd4, "memtoreg_issue_x4");
            wb_rd         = 5'd4;
            wb_regwrite   = 1'b1;
            wb_release    = 1'b1;
            wb_memtoreg   = sel[i];
            wb_alu_output = 32'hA0A0_A0A0;
            wb_mem_output = 32'hDEAD_BEEF;
            wb_pc_plus_4  = 32'h0000_0104;
            wb_imm        = 32'hABCD_E000;
            #1;
            checks++;
            if (wb_data !== exp[i]) begin errors++; $display("FAIL memtoreg_sel%0d: wb_data=%h expected %h", sel[i], wb_data, exp[i]); end
            next_cycle();
            id_rs2 = 5'd4;
            #1;
            checks++;
            if (rs2_data !== exp[i]) begin errors++; $display("FAIL memtoreg_x4_sel%0d: rs2_data=%h expected %h", sel[i], rs2_data, exp[i]); end
            next_cycle();
        end
        // x0 write is discarded.
        wb_write(5'd0, 32'hFFFF_FFFF);
        id_rs1 = 5'd0;
        #1;
        checks++;
        if (rs1_data !== 32'h0) begin errors++; $display("FAIL x0_same_cycle: rs1_data=%h expected 0", rs1_data); end
        next_cycle();
        id_rs1 = 5'd0;
        #1;
        checks++;
        if (rs1_data !== 32'h0) begin errors++; $display("FAIL x0_next_cycle: rs1_data=%h expected 0", rs1_data); end
        next_cycle();
    endtask

    task automatic test_raw();
        issue_rd(5'd7, "raw_issue_x7");
        for (int i = 0; i < 3; i++) begin
            id_valid = 1'b1;
            id_rs2   = 5'd7;
            #1;
            checks++;
            if (stall !== 1'b1) begin errors++; $display("FAIL raw_wait%0d: stall=%b expected 1", i, stall); end
            next_cycle();
        end
        id_valid = 1'b1;
        id_rs2   = 5'd7;
        wb_write(5'd7, 32'h0000_0055);
        #1;
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL raw_release_stall: stall=%b expected 0", stall); end
        checks++;
        if (rs2_data !== 32'h0000_0055) begin errors++; $display("FAIL raw_release_data: rs2_data=%h expected 00000055", rs2_data); end
        next_cycle();
        // rs1 port detects hazards as well.
        issue_rd(5'd8, "raw_issue_x8");
        id_valid = 1'b1;
        id_rs1   = 5'd8;
        #1;
        checks++;
        if (stall !== 1'b1) begin errors++; $display("FAIL raw_rs1: stall=%b expected 1", stall); end
        next_cycle();
        wb_write(5'd8, 32'h0000_0088);
        next_cycle();
    endtask

    task automatic test_waw();
        issue_rd(5'd9, "waw_issue1");
        issue_rd(5'd9, "waw_issue2");
        issue_rd(5'd9, "waw_issue3");
        for (int i = 0; i < 2; i++) begin
            id_valid = 1'b1; id_rd = 5'd9; id_regwrite = 1'b1;
            #1;
            checks++;
            if (stall !== 1'b1) begin errors++; $display("FAIL waw_sat%0d: stall=%b expected 1", i, stall); end
            next_cycle();
        end
        // Release cycle: saturation still judged on the raw count of 3.
        id_valid = 1'b1; id_rd = 5'd9; id_regwrite = 1'b1;
        wb_write(5'd9, 32'h0000_0091);
        #1;
        checks++;
        if (stall !== 1'b1) begin errors++; $display("FAIL waw_release_cycle: stall=%b expected 1", stall); end
        next_cycle();
        id_valid = 1'b1; id_rd = 5'd9; id_regwrite = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL waw_fourth_issue: stall=%b expected 0", stall); end
        next_cycle();
        // Count is 3 again: drain it; at count 1 a same-cycle release clears the RAW.
        wb_write(5'd9, 32'h0000_0092);
        next_cycle();
        wb_write(5'd9, 32'h0000_0093);
        next_cycle();
        id_valid = 1'b1; id_rs1 = 5'd9;
        #1;
        checks++;
        if (stall !== 1'b1) begin errors++; $display("FAIL waw_cnt1_hold: stall=%b expected 1", stall); end
        wb_write(5'd9, 32'h0000_0094);
        #1;
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL waw_last_release: stall=%b expected 0", stall); end
        checks++;
        if (rs1_data !== 32'h0000_0094) begin errors++; $display("FAIL waw_last_data: rs1_data=%h expected 00000094", rs1_data); end
        next_cycle();
    endtask

    task automatic test_squash();
        issue_rd(5'd10, "squash_issue_a");
        wb_write(5'd10, 32'h1010_1010);
        next_cycle();
        issue_rd(5'd10, "squash_issue_b");
        id_valid      = 1'b1;
        id_rs1        = 5'd10;
        wb_rd         = 5'd10;
        wb_release    = 1'b1;
        wb_regwrite   = 1'b0;
        wb_alu_output = 32'hDEAD_0000;
        #1;
        checks++;
        if (rs1_data !== 32'h1010_1010) begin errors++; $display("FAIL squash_no_bypass: rs1_data=%h expected 10101010", rs1_data); end
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL squash_release_stall: stall=%b expected 0", stall); end
        next_cycle();
        id_valid = 1'b1;
        id_rs1   = 5'd10;
        #1;
        checks++;
        if (rs1_data !== 32'h1010_1010) begin errors++; $display("FAIL squash_regs_kept: rs1_data=%h expected 10101010", rs1_data); end
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL squash_cnt_zero: stall=%b expected 0", stall); end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        issue_rd(5'd11, "simul_issue_x11");
        // Issue and release of x11 in the same cycle.
        id_valid = 1'b1; id_rd = 5'd11; id_regwrite = 1'b1;
        wb_write(5'd11, 32'h0000_0011);
        #1;
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL simul_issue: stall=%b expected 0", stall); end
        next_cycle();
        id_valid = 1'b1; id_rs1 = 5'd11;
        #1;
        checks++;
        if (stall !== 1'b1) begin errors++; $display("FAIL simul_cnt_nonzero: stall=%b expected 1", stall); end
        wb_write(5'd11, 32'h0000_0012);
        #1;
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL simul_cnt_one: stall=%b expected 0", stall); end
        next_cycle();
    endtask

    task automatic test_reset_mid();
        issue_rd(5'd12, "rstmid_issue_x12a");
        issue_rd(5'd12, "rstmid_issue_x12b");
        issue_rd(5'd13, "rstmid_issue_x13");
        id_valid = 1'b1; id_rs1 = 5'd12; id_rs2 = 5'd13;
        #1;
        checks++;
        if (stall !== 1'b1) begin errors++; $display("FAIL rstmid_before: stall=%b expected 1", stall); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL rstmid_async_clear: stall=%b expected 0", stall); end
        id_rs1 = 5'd3;
        #1;
        checks++;
        if (rs1_data !== 32'h0) begin errors++; $display("FAIL rstmid_regs_clear: rs1_data=%h expected 0", rs1_data); end
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        id_valid = 1'b1; id_rs1 = 5'd12; id_rs2 = 5'd13;
        #1;
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL rstmid_after: stall=%b expected 0", stall); end
        next_cycle();
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        @(negedge clk);
        test_reset();
        test_bypass();
        test_memtoreg();
        test_raw();
        test_waw();
        test_squash();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
